// File: rtl/spi_arbiter_if.sv
// Signal bundle between spi_arbiter, its requesters and the SPI master peripheral.
// master: the arbiter side; slave: requesters plus SPI peripheral.
interface spi_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_data;
  logic [3*NUM_REQ-1:0]  req_ss;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [NUM_REQ-1:0]    err;
  logic [7:0]            rd_data;
  logic                  wrt_SPI;
  logic [15:0]           SPI_data;
  logic [2:0]            ss;
  logic                  SPI_done;
  logic [7:0]            EEP_data;

  modport master (
    input  req, req_data, req_ss, SPI_done, EEP_data,
    output gnt, done, err, rd_data, wrt_SPI, SPI_data, ss
  );

  modport slave (
    output req, req_data, req_ss, SPI_done, EEP_data,
    input  gnt, done, err, rd_data, wrt_SPI, SPI_data, ss
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SPI_TIMEOUT_EN.
module spi_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic           clk,
  input logic           rst_n,
  spi_arbiter_if.master bus
);
  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W    = PTR_W + 1;
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
`ifdef SPI_TIMEOUT_EN
  localparam int unsigned WCNT_W   = $clog2(TIMEOUT_CYC + 1);
`endif

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("spi_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [7:0]         rd_q, rd_d;
  logic               wrt_q, wrt_d;
  logic [15:0]        data_q, data_d;
  logic [2:0]         ss_q, ss_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
`ifdef SPI_TIMEOUT_EN
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
`endif

  logic [15:0]        data_arr [NUM_REQ];
  logic [2:0]         ss_arr   [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   winner_nxt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i] = bus.req_data[16*i +: 16];
    assign ss_arr[i]   = bus.req_ss[3*i +: 3];
  end

  // Index addition modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W-1:0] off);
    logic [SUM_W-1:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= SUM_W'(NUM_REQ)) s = s - SUM_W'(NUM_REQ);
    return PTR_W'(s);
  endfunction

  // First eligible requester at or above rr_q; the current done holder is masked.
  always_comb begin
    eligible = bus.req & ~done_q;
    found    = 1'b0;
    winner   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && eligible[wrap_add(rr_q, PTR_W'(k))]) begin
        found  = 1'b1;
        winner = wrap_add(rr_q, PTR_W'(k));
      end
    end
    winner_nxt = wrap_add(winner, PTR_W'(1));
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rd_d    = rd_q;
    wrt_d   = 1'b0;
    data_d  = data_q;
    ss_d    = ss_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
`ifdef SPI_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          data_d  = data_arr[winner];
          ss_d    = ss_arr[winner];
          gnt_d   = NUM_REQ'(1) << winner;
          rr_d    = winner_nxt;
          wrt_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef SPI_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      WAIT: begin
        if (bus.SPI_done) begin
          rd_d    = bus.EEP_data;
          done_d  = gnt_q;
          gnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? IDLE : GAP;
        end
`ifdef SPI_TIMEOUT_EN
        // Watchdog expiry completes the transaction with an error flag.
        else if (wcnt_q == WCNT_W'(TIMEOUT_CYC - 1)) begin
          rd_d    = 8'hFF;
          done_d  = gnt_q;
          err_d   = gnt_q;
          gnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? IDLE : GAP;
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d   = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rd_q    <= 8'h00;
      wrt_q   <= 1'b0;
      data_q  <= 16'h0000;
      ss_q    <= 3'b000;
      rr_q    <= '0;
      gap_q   <= '0;
`ifdef SPI_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wrt_q   <= wrt_d;
      data_q  <= data_d;
      ss_q    <= ss_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
`ifdef SPI_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rd_data  = rd_q;
  assign bus.wrt_SPI  = wrt_q;
  assign bus.SPI_data = data_q;
  assign bus.ss       = ss_q;
endmodule
